// File: rtl/pc_stack_seq_if.sv
// Bundle of control inputs and status outputs for the PC sequencer with return stack.
// The master drives the operation; the slave (the sequencer) reports PC and stack status.
interface pc_stack_seq_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    logic                         en;
    logic [2:0]                   op;
    logic [WIDTH-1:0]             in;
    logic                         err_clr;
    logic [WIDTH-1:0]             PC;
    logic [$clog2(DEPTH+1)-1:0]   sp;
    logic                         full;
    logic                         empty;
    logic                         err;

    modport master (
        output en, op, in, err_clr,
        input  PC, sp, full, empty, err
    );

    modport slave (
        input  en, op, in, err_clr,
        output PC, sp, full, empty, err
    );
endinterface

// File: rtl/pc_stack_seq.sv
// Program counter sequencer with jump, relative branch, call/return and a LIFO return stack.
// Stack over/underflow leaves state untouched and raises a sticky error flag.
module pc_stack_seq #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input logic           clk,
    input logic           rst,
    pc_stack_seq_if.slave bus
);
    localparam int unsigned SpW  = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [SpW-1:0] SpFull = SpW'(DEPTH);

    localparam logic [2:0] OpInc   = 3'b001;
    localparam logic [2:0] OpJmp   = 3'b010;
    localparam logic [2:0] OpRel   = 3'b011;
    localparam logic [2:0] OpCallA = 3'b100;
    localparam logic [2:0] OpCallR = 3'b101;
    localparam logic [2:0] OpRet   = 3'b110;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SpW-1:0]   sp_q, sp_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];

    logic             full, empty;
    logic             push, fault;
    logic [WIDTH-1:0] ret_addr;
    logic [PtrW-1:0]  wr_idx, rd_idx;

    assign full     = (sp_q == SpFull);
    assign empty    = (sp_q == '0);
    assign ret_addr = pc_q + WIDTH'(1);
    assign wr_idx   = PtrW'(sp_q);
    assign rd_idx   = PtrW'(sp_q - SpW'(1));

    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        push  = 1'b0;
        fault = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OpInc:   pc_d = ret_addr;
                OpJmp:   pc_d = bus.in;
                OpRel:   pc_d = pc_q + bus.in;
                OpCallA, OpCallR: begin
                    if (full) begin
                        fault = 1'b1;
                    end else begin
                        push = 1'b1;
                        sp_d = sp_q + SpW'(1);
                        pc_d = (bus.op == OpCallA) ? bus.in : pc_q + bus.in;
                    end
                end
                OpRet: begin
                    if (empty) begin
                        fault = 1'b1;
                    end else begin
                        sp_d = sp_q - SpW'(1);
                        pc_d = stack_q[rd_idx];
                    end
                end
                default: ;
            endcase
        end
        // A fresh fault outranks a clear on the same edge.
        if (fault) begin
            err_d = 1'b1;
        end else if (bus.err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Entries carry no reset; only locations below sp are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[wr_idx] <= ret_addr;
        end
    end

    assign bus.PC    = pc_q;
    assign bus.sp    = sp_q;
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_pc_stack_seq.sv
// Randomized and directed checks of pc_stack_seq against a queue-based reference model.
module tb_pc_stack_seq;
    localparam int unsigned W  = 16;
    localparam int unsigned D  = 8;
    localparam logic [W-1:0] RV = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pc_stack_seq_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pc_stack_seq #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: PC as a plain number, return stack as a queue.
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stack [$];
    logic         m_err;

    function automatic logic [W+6:0] exp_vec();
        logic [3:0] n;
        n = 4'(m_stack.size());
        return {m_pc, n, (m_stack.size() == D), (m_stack.size() == 0), m_err};
    endfunction

    function automatic logic [W+6:0] dut_vec();
        return {bus.PC, bus.sp, bus.full, bus.empty, bus.err};
    endfunction

    function automatic void model_reset();
        m_pc  = RV;
        m_err = 1'b0;
        m_stack.delete();
    endfunction

    function automatic void model_step(logic en, logic [2:0] op, logic [W-1:0] in, logic clr);
        logic         fault;
        logic [W-1:0] ra;
        fault = 1'b0;
        ra    = m_pc + 16'd1;
        if (en) begin
            case (op)
                3'd1: m_pc = ra;
                3'd2: m_pc = in;
                3'd3: m_pc = m_pc + in;
                3'd4, 3'd5: begin
                    if (m_stack.size() == D) fault = 1'b1;
                    else begin
                        m_stack.push_back(ra);
                        m_pc = (op == 3'd4) ? in : m_pc + in;
                    end
                end
                3'd6: begin
                    if (m_stack.size() == 0) fault = 1'b1;
                    else m_pc = m_stack.pop_back();
                end
                default: ;
            endcase
        end
        if (fault) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endfunction

    task automatic drive(input logic en, input logic [2:0] op, input logic [W-1:0] in,
                         input logic clr);
        bus.en      = en;
        bus.op      = op;
        bus.in      = in;
        bus.err_clr = clr;
        @(posedge clk);
        model_step(en, op, in, clr);
        #1;
    endtask

    task automatic do_reset();
        bus.en = 1'b0; bus.op = 3'd0; bus.in = '0; bus.err_clr = 1'b0;
        rst = 1'b1;
        #3;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (dut_vec() !== {RV, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h want %h", dut_vec(), {RV, 4'd0, 1'b0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 3'd1, 16'h0, 1'b0);
            vectors++;
            if (dut_vec() !== {16'(i), 4'd0, 1'b0, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL count_%0d: got %h want %h", i, dut_vec(),
                         {16'(i), 4'd0, 1'b0, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_call_ret();
        do_reset();
        drive(1'b1, 3'd2, 16'h0010, 1'b0);
        drive(1'b1, 3'd4, 16'h0200, 1'b0);
        vectors++;
        if (bus.PC !== 16'h0200 || bus.sp !== 4'd1) begin
            miscompares++;
            $display("FAIL call_abs: got pc=%h sp=%0d want pc=0200 sp=1", bus.PC, bus.sp);
        end
        drive(1'b1, 3'd6, 16'h1234, 1'b0);
        vectors++;
        if (bus.PC !== 16'h0011 || bus.sp !== 4'd0 || bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL return: got pc=%h sp=%0d want pc=0011 sp=0", bus.PC, bus.sp);
        end
        drive(1'b1, 3'd2, 16'h0300, 1'b0);
        drive(1'b1, 3'd5, 16'hFFF0, 1'b0);
        vectors++;
        if (bus.PC !== 16'h02F0 || bus.sp !== 4'd1) begin
            miscompares++;
            $display("FAIL call_rel: got pc=%h sp=%0d want pc=02f0 sp=1", bus.PC, bus.sp);
        end
        drive(1'b1, 3'd6, 16'h0, 1'b0);
        vectors++;
        if (bus.PC !== 16'h0301) begin
            miscompares++;
            $display("FAIL return_rel: got pc=%h want pc=0301", bus.PC);
        end
    endtask

    task automatic test_arith();
        do_reset();
        drive(1'b1, 3'd2, 16'h0100, 1'b0);
        drive(1'b1, 3'd3, 16'hFFFE, 1'b0);
        vectors++;
        if (bus.PC !== 16'h00FE) begin
            miscompares++;
            $display("FAIL rel_neg: got pc=%h want pc=00fe", bus.PC);
        end
        drive(1'b1, 3'd2, 16'hFFFF, 1'b0);
        drive(1'b1, 3'd1, 16'h0, 1'b0);
        vectors++;
        if (bus.PC !== 16'h0000) begin
            miscompares++;
            $display("FAIL inc_wrap: got pc=%h want pc=0000", bus.PC);
        end
        for (int op = 0; op < 8; op += 7) begin
            drive(1'b1, 3'(op), 16'hABCD, 1'b0);
            vectors++;
            if (bus.PC !== 16'h0000) begin
                miscompares++;
                $display("FAIL hold_op%0d: got pc=%h want pc=0000", op, bus.PC);
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 3'd4, 16'($urandom), 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fill_call_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        vectors++;
        if (bus.full !== 1'b1) begin
            miscompares++;
            $display("FAIL full_flag: got %b want 1", bus.full);
        end
        drive(1'b1, 3'd5, 16'h0040, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec() || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got %h want %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < D; i++) begin
            drive(1'b1, 3'd6, 16'h0, 1'b0);
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL lifo_ret_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        drive(1'b1, 3'd6, 16'h0, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec() || bus.err !== 1'b1 || bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: got %h want %h", dut_vec(), exp_vec());
        end
        drive(1'b0, 3'd0, 16'h0, 1'b1);
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clr: got err=%b want 0", bus.err);
        end
    endtask

    task automatic test_enable();
        do_reset();
        drive(1'b1, 3'd4, 16'h0500, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 3'd4, 16'h0777, 1'b0);
            vectors++;
            if (bus.PC !== 16'h0500 || bus.sp !== 4'd1 || bus.err !== 1'b0) begin
                miscompares++;
                $display("FAIL en_freeze_%0d: got pc=%h sp=%0d err=%b want pc=0500 sp=1 err=0",
                         i, bus.PC, bus.sp, bus.err);
            end
        end
        drive(1'b1, 3'd6, 16'h0, 1'b0);
        drive(1'b1, 3'd6, 16'h0, 1'b1);
        vectors++;
        if (bus.err !== 1'b1 || bus.PC !== 16'h0001) begin
            miscompares++;
            $display("FAIL fault_beats_clr: got err=%b pc=%h want err=1 pc=0001", bus.err, bus.PC);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 3'd4, 16'h0100 + 16'(i), 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (bus.PC !== RV || bus.sp !== 4'd0 || bus.empty !== 1'b1 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: got pc=%h sp=%0d want pc=%h sp=0", bus.PC, bus.sp, RV);
        end
        #1;
        rst = 1'b0;
        drive(1'b1, 3'd6, 16'h0, 1'b0);
        vectors++;
        if (dut_vec() !== exp_vec() || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL ret_after_rst: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                  ($urandom_range(0, 9) == 0));
            vectors++;
            if (dut_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        bus.en = 1'b0; bus.op = 3'd0; bus.in = '0; bus.err_clr = 1'b0;
        model_reset();
        test_reset();
        test_count();
        test_call_ret();
        test_arith();
        test_fill();
        test_enable();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_stack_seq.md
PC_STACK_SEQ -- requirements
Module: pc_stack_seq

Interface
REQ-001 Parameter WIDTH, default 16, sets the width of PC, in, and every return-stack entry.
REQ-002 Parameter DEPTH, default 8, sets the number of return-stack entries; legal values are 2 to 64.
REQ-003 Parameter RESET_VEC, default 0, sets the PC value loaded on reset.
REQ-004 clk input 1: the only clock; every state update happens on its rising edge.
REQ-005 rst input 1: asynchronous, active-high reset.
REQ-006 en input 1: advance enable; en=0 freezes all state except err_clr handling.
REQ-007 op input 3: operation select, decoded per REQ-012.
REQ-008 in input WIDTH: absolute target or two's-complement offset.
REQ-009 err_clr input 1: clears the sticky err flag.
REQ-010 PC output WIDTH: the current program counter, driven directly from a register.
REQ-011 sp output $clog2(DEPTH+1): stack occupancy, 0..DEPTH; full output 1 = (sp==DEPTH); empty output 1 = (sp==0); err output 1: sticky stack fault.

Function
REQ-012 With en=1, op SHALL act at the clock edge as follows:
- 000: hold.
- 001: PC<=PC+1.
- 010: PC<=in.
- 011: PC<=PC+in.
- 100: call absolute; push PC+1, then PC<=in.
- 101: call relative; push PC+1, then PC<=PC+in.
- 110: return; pop the top entry into PC.
- 111: hold (reserved).
REQ-013 All PC arithmetic SHALL be modulo 2^WIDTH with no carry or flag; for example, PC=16'hFFFF with op 001 gives 16'h0000.
REQ-014 The pushed return address SHALL be PC+1 modulo 2^WIDTH, computed from the PC value before the edge.
REQ-015 A push SHALL write stack[sp] and increment sp; a pop SHALL read stack[sp-1] and decrement sp; both changes take effect in the same edge as the PC update.
REQ-016 A call with full=1 SHALL leave PC, sp and the stack unchanged and set err.
REQ-017 A return with empty=1 SHALL leave PC and sp unchanged and set err.
REQ-018 With en=0, PC, sp and the stack SHALL hold regardless of op, and no error SHALL be flagged.
REQ-019 err SHALL be sticky; err_clr=1 SHALL clear it at the next edge regardless of en.
REQ-020 If a new fault and err_clr occur on the same edge, the fault SHALL win and err SHALL be 1.
REQ-021 full, empty and sp SHALL be combinational functions of the registered occupancy, so they are valid in the same cycle as PC.
REQ-022 Latency SHALL be one cycle: PC reflects the op sampled at edge N immediately after edge N; there is no bypass from in to PC.
REQ-023 Stack contents above sp SHALL be don't-care; a return after a call SHALL yield exactly the pushed value.

Reset
REQ-024 Asserting rst SHALL immediately, without waiting for clk, set PC=RESET_VEC, sp=0, empty=1, full=0 and err=0.
REQ-025 Stack entry contents SHALL NOT be required to reset.
REQ-026 rst asserted mid-sequence SHALL discard all pending return addresses; the first op after deassertion SHALL act on PC=RESET_VEC.
REQ-027 rst SHALL take priority over en, op and err_clr.

Verification
REQ-028 Reset then 3x op 001 -> PC=0,1,2,3; sp=0; empty=1.
REQ-029 PC=16'h0010, op 100 with in=16'h0200 -> PC=16'h0200, sp=1; then op 110 -> PC=16'h0011, sp=0.
REQ-030 PC=16'h0100, op 011 with in=16'hFFFE -> PC=16'h00FE; PC=16'hFFFF, op 001 -> PC=16'h0000.
REQ-031 Fill the stack with 8 calls (DEPTH=8) -> full=1; a 9th call -> PC and sp unchanged, err=1; 8 returns -> return addresses popped in LIFO order, empty=1; a further return -> PC unchanged, err stays 1; err_clr -> err=0.
REQ-032 en=0 with op 100 held for 3 cycles -> PC and sp frozen, err=0; a simultaneous fault and err_clr -> err=1.
REQ-033 Assert rst asynchronously between edges with sp=3 -> PC=RESET_VEC and sp=0 before the next edge; the following op 110 -> err=1.
